// File: rtl/mod_mul_pow2_pkg.sv
// Shared constants and FSM encoding for the modular multiply-by-power-of-two block.
// The prime modulus CHAR is a compile-time constant; operands are DEFAULT_WORD_SIZE bits wide.
package mod_mul_pow2_pkg;

   localparam int DEFAULT_WORD_SIZE  = 8;
   localparam int CHAR               = 251;
   localparam int MUL_POW2_CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mod_mul_pow2_mul2.sv
// Combinational modular doubling: c = 2*a mod P for a < P.
// One adder forms 2a - P; its borrow bit selects between 2a and 2a - P.
module mod_mul_pow2_mul2
   import mod_mul_pow2_pkg::*;
#(
   parameter int                   WORD_SIZE = DEFAULT_WORD_SIZE,
   parameter logic [WORD_SIZE-1:0] P         = WORD_SIZE'(CHAR)
) (
   input  logic [WORD_SIZE-1:0] a,
   output logic [WORD_SIZE-1:0] c
);

   logic [WORD_SIZE:0] d_s;
   logic [WORD_SIZE:0] t_s;

   // Double, subtract P once, keep the non-negative candidate
   always_comb begin
      d_s = {a, 1'b0};
      t_s = d_s + {1'b1, ~P} + {{WORD_SIZE{1'b0}}, 1'b1};
      if (t_s[WORD_SIZE]) begin
         c = d_s[WORD_SIZE-1:0];
      end else begin
         c = t_s[WORD_SIZE-1:0];
      end
   end

endmodule

// File: rtl/mod_mul_pow2.sv
// Computes c = a * 2^k mod CHAR by iterated modular doubling behind a valid/ready handshake.
// Define MUL_POW2_DUAL_STEP_EN to apply two chained doublings per RUN cycle.
module mod_mul_pow2
   import mod_mul_pow2_pkg::*;
#(
   parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
   parameter int CNT_WIDTH = MUL_POW2_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] a,
   input  logic [CNT_WIDTH-1:0] k,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] c
);

   localparam logic [WORD_SIZE-1:0] P_MOD    = WORD_SIZE'(CHAR);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

   state_e                 state_q, state_d;
   logic [WORD_SIZE-1:0]   x_q, x_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [WORD_SIZE-1:0]   c_q, c_d;
   logic                   out_valid_q, out_valid_d;
   logic                   in_ready_q, in_ready_d;
   logic                   accept_s;
   logic                   handshake_s;
   logic [WORD_SIZE-1:0]   dbl1_s;

   mod_mul_pow2_mul2 #(.WORD_SIZE(WORD_SIZE), .P(P_MOD)) u_mul2_a (
      .a (x_q),
      .c (dbl1_s)
   );

`ifdef MUL_POW2_DUAL_STEP_EN
   localparam logic [CNT_WIDTH-1:0] CNT_TWO = CNT_WIDTH'(32'd2);
   logic [WORD_SIZE-1:0] dbl2_s;

   mod_mul_pow2_mul2 #(.WORD_SIZE(WORD_SIZE), .P(P_MOD)) u_mul2_b (
      .a (dbl1_s),
      .c (dbl2_s)
   );
`endif

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      cnt_d       = cnt_q;
      c_d         = {WORD_SIZE{1'b0}};
      out_valid_d = 1'b0;
      accept_s    = in_valid && in_ready_q;
      handshake_s = out_valid_q && out_ready;

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               x_d   = a;
               cnt_d = k;
               if (k != CNT_ZERO) begin
                  state_d = RUN;
               end else begin
                  state_d = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
`ifdef MUL_POW2_DUAL_STEP_EN
            // Two doublings while at least two remain; a lone odd step finishes with one
            if (cnt_q >= CNT_TWO) begin
               x_d   = dbl2_s;
               cnt_d = cnt_q - CNT_TWO;
            end else begin
               x_d   = dbl1_s;
               cnt_d = cnt_q - CNT_ONE;
            end
            if (cnt_q <= CNT_TWO) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
`else
            x_d   = dbl1_s;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
`endif
         end
         DONE: begin
            // The first DONE cycle loads the result; it then holds until accepted
            if (handshake_s) begin
               state_d = IDLE;
            end else begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               c_d         = x_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= {WORD_SIZE{1'b0}};
         cnt_q       <= CNT_ZERO;
         c_q         <= {WORD_SIZE{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         cnt_q       <= cnt_d;
         c_q         <= c_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign c         = c_q;

endmodule
